// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port dmem.
// Latency: gnt_o at cycle 0, mem_req_o at cycle 1, done_o/rdata_o at cycle 2; +2 cycles per refusal.
// Backpressure: requesters hold req_i until gnt_o; a refused command is re-issued unchanged.
//
// Ports:
//   clk, reset_n_i          single clock, synchronous active-low reset
//   req_i/we_i[1:0]         per-requester level request and write enable
//   addr0_i/addr1_i         per-requester address
//   wdata0_i/wdata1_i       per-requester write data
//   gnt_o[1:0]              one-cycle pulse, command of that requester latched this edge
//   done_o[1:0], err_o      one-cycle completion pulse; err_o marks a retry-limit abort
//   rdata_o                 read data, valid with done_o of a read
//   mem_*                   dmem command (req/we/addr/din) and response (dout/refused)
// Optional feature: define DMEM_ARB_RETRY_LIMIT_EN to abort after MAX_RETRY re-issues.
module dmem_arbiter #(
  parameter int A_WIDTH   = 13,
  parameter int D_WIDTH   = 34,
  parameter int MAX_RETRY = 7
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic [1:0]         req_i,
  input  logic [1:0]         we_i,
  input  logic [A_WIDTH-1:0] addr0_i,
  input  logic [A_WIDTH-1:0] addr1_i,
  input  logic [D_WIDTH-1:0] wdata0_i,
  input  logic [D_WIDTH-1:0] wdata1_i,
  output logic [1:0]         gnt_o,
  output logic [1:0]         done_o,
  output logic               err_o,
  output logic [D_WIDTH-1:0] rdata_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [A_WIDTH-1:0] mem_addr_o,
  output logic [D_WIDTH-1:0] mem_din_o,
  input  logic [D_WIDTH-1:0] mem_dout_i,
  input  logic               mem_refused_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_cmd_id;
  logic                 r_cmd_we;
  logic [A_WIDTH-1:0]   r_cmd_addr;
  logic [D_WIDTH-1:0]   r_cmd_data;
  logic                 r_last_winner;

  logic                 w_resp;
  logic                 w_abort;
  logic                 w_finish;
  logic                 w_done;
  logic                 w_arb;
  logic                 w_winner;
  logic                 w_grant;

  assign w_resp = (r_state == ST_RESP);

`ifdef DMEM_ARB_RETRY_LIMIT_EN
  logic [2:0] r_retry_cnt;
  // Abort when the command was refused again after its last allowed re-issue.
  assign w_abort = w_resp && mem_refused_i && (r_retry_cnt == 3'(MAX_RETRY));
`else
  assign w_abort = 1'b0;
`endif

  // A transaction ends on an accepted response (or an abort); arbitration
  // for the next one overlaps that cycle.
  assign w_finish = w_resp && (!mem_refused_i || w_abort);
  assign w_arb    = (r_state == ST_IDLE) || w_finish;
  // Tie goes to the port that did not win last; otherwise the lone requester.
  assign w_winner = (&req_i) ? ~r_last_winner : req_i[1];
  // Pulses are suppressed while reset is asserted so nothing is granted or
  // completed on an edge that discards the state.
  assign w_grant  = w_arb && (|req_i) && reset_n_i;
  assign w_done   = w_finish && reset_n_i;

  always_comb begin
    w_state_nxt = r_state;
    gnt_o       = 2'b00;
    done_o      = 2'b00;
    err_o       = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = r_cmd_addr;
    mem_din_o   = r_cmd_data;

    case (r_state)
      ST_IDLE: begin
        if (|req_i) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = r_cmd_we;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (!w_finish)    w_state_nxt = ST_ISSUE;
        else if (|req_i)  w_state_nxt = ST_ISSUE;
        else              w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_grant) gnt_o = w_winner ? 2'b10 : 2'b01;
    if (w_done) begin
      done_o  = r_cmd_id ? 2'b10 : 2'b01;
      err_o   = w_abort;
      rdata_o = mem_dout_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_state       <= ST_IDLE;
      r_cmd_id      <= 1'b0;
      r_cmd_we      <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_data    <= '0;
      r_last_winner <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_cmd_id      <= w_winner;
        r_cmd_we      <= we_i[w_winner];
        r_cmd_addr    <= w_winner ? addr1_i : addr0_i;
        r_cmd_data    <= w_winner ? wdata1_i : wdata0_i;
        r_last_winner <= w_winner;
      end
    end
  end

`ifdef DMEM_ARB_RETRY_LIMIT_EN
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_retry_cnt <= 3'd0;
    end else if (w_grant) begin
      r_retry_cnt <= 3'd0;
    end else if (w_resp && mem_refused_i && !w_abort) begin
      r_retry_cnt <= r_retry_cnt + 3'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port data memory (`dmem`, 13-bit address, 34-bit data). It shares the memory between requester 0 (execution-unit load/store) and requester 1 (debug/DMA port). It grants round-robin and registers the winning command. It issues the command for one cycle, then samples the memory's registered `refused_o` and read data on the following cycle, and either completes the transaction or re-issues it unchanged.

## Interface
Parameters:
- `A_WIDTH`, 13, memory address width
- `D_WIDTH`, 34, memory data width
- `MAX_RETRY`, 7, re-issues allowed before error (used only with retry limit enabled)

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `reset_n_i`  in  1  reset, synchronous, active-low
- `req_i[1:0]`  in  2  per-requester request, level; held until `gnt_o` bit seen
- `we_i[1:0]`  in  2  per-requester write enable (1 = write)
- `addr0_i`, `addr1_i`  in  A_WIDTH  per-requester address
- `wdata0_i`, `wdata1_i`  in  D_WIDTH  per-requester write data
- `gnt_o[1:0]`  out  2  one-cycle pulse; command of that requester latched this edge
- `done_o[1:0]`  out  2  one-cycle pulse; transaction of that requester complete
- `err_o`  out  1  with `done_o`: transaction aborted after retry limit
- `rdata_o`  out  D_WIDTH  read data, valid when `done_o` pulses for a read
- `mem_req_o`  out  1  to `dmem` `read_write_req_i`
- `mem_we_o`  out  1  to `dmem` `write_en_i`
- `mem_addr_o`  out  A_WIDTH  to `dmem` `addr_i`
- `mem_din_o`  out  D_WIDTH  to `dmem` `din_i`
- `mem_dout_i`  in  D_WIDTH  from `dmem` `dout_o` (valid the cycle after a read issue)
- `mem_refused_i`  in  1  from `dmem` `refused_o` (valid the cycle after an issue)

## Operation
- States: IDLE, ISSUE, RESP.
- Command registers: `cmd_id`, `cmd_we`, `cmd_addr`, `cmd_data`, and `retry_cnt` (3 bits).
- **Arbitration** is evaluated in IDLE, and in RESP when the current transaction completes.
  - Only one request pending: that requester wins.
  - Both pending: the requester other than `last_winner` wins.
  - Winner: `gnt_o[w]`=1 for that cycle; command registers load at the edge; `last_winner`<=w; `retry_cnt`<=0; next state ISSUE.
  - No request pending: next state IDLE.
- **ISSUE**: `mem_req_o`=1, `mem_we_o`=`cmd_we`, `mem_addr_o`=`cmd_addr`, `mem_din_o`=`cmd_data`. Next state RESP.
- **RESP**: `mem_req_o`=0, `mem_we_o`=0.
  - `mem_refused_i`=1: re-issue the same command. `retry_cnt`++, next state ISSUE. No `done_o`, no new grant.
  - `mem_refused_i`=0: `done_o[cmd_id]`=1 and `rdata_o`=`mem_dout_i`, registered-through combinationally (for writes, `rdata_o` is don't-care). Arbitrate the same cycle.
- Writes that were refused are re-issued. Re-writing the same data is idempotent.
- Outside ISSUE, `mem_addr_o`/`mem_din_o` hold the last command; `mem_req_o`=`mem_we_o`=0.
- A requester's `req_i` bit asserted while its own command is outstanding is not a new request until that command's `done_o` has pulsed. Requesters deassert `req_i` after `gnt_o`.

## Timing
- Reset (`reset_n_i`=0 at an edge):
  - state IDLE; `last_winner`=1, so port 0 wins the first tie; `retry_cnt`=0; command registers 0.
  - Outputs: `gnt_o`=0, `done_o`=0, `err_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_din_o`=0, `rdata_o`=0.
- Reset mid-transaction: the in-flight command is dropped silently. No `done_o` is issued and there is no re-issue after reset.
- Latency with no refusal:
  - cycle 0: `gnt_o`
  - cycle 1: `mem_req_o`
  - cycle 2: `done_o` and `rdata_o`
- Each refusal adds 2 cycles.
- Back-to-back throughput: one transaction per 2 cycles, because the grant overlaps RESP.
- Simultaneous completion and a pending request: the grant in the RESP cycle follows the round-robin rule, with `last_winner` as updated at that cycle's previous grant.

## Configuration
- `DMEM_ARB_RETRY_LIMIT_EN` defined:
  - In RESP with `mem_refused_i`=1 and `retry_cnt`==`MAX_RETRY`: pulse `done_o[cmd_id]` with `err_o`=1, do not re-issue, and arbitrate.
  - `rdata_o` is don't-care on error.
- Undefined: retries are unbounded; `retry_cnt` is not implemented; `err_o` is tied 0.

## Test plan
- Port 0 read of addr 0x0005 after a memory preload of 0x3_0000_00A5, no refusals → `gnt_o`=01 at cycle 0, `mem_req_o`=1/`mem_we_o`=0 at cycle 1, `done_o`=01 with `rdata_o`=0x3_0000_00A5 at cycle 2.
- Both ports request continuously from reset: port 0 write 0x1234 to 0x10, port 1 write 0x5678 to 0x11 → grants alternate 01,10,01,… every 2 cycles; readback gives 0x1234 and 0x5678.
- Force `mem_refused_i`=1 for two RESP cycles on a port 1 read → two re-issues with identical addr; `done_o`=10 arrives 6 cycles after the grant; no `gnt_o` meanwhile.
- With `DMEM_ARB_RETRY_LIMIT_EN` and `MAX_RETRY`=7, refusal held permanently → 8 issues, then `done_o` with `err_o`=1; the next pending request is granted the same cycle.
- Drop `reset_n_i` for one edge in RESP of a port 0 read → no `done_o`; all outputs at reset values the next cycle; the pending port 1 request is granted the first cycle after release.
